// File: rtl/instr_encoder.sv
// Instruction encoder: packs a field bundle into a 32-bit instruction word.
// Legal words are buffered in a 4-entry FIFO and drained through a
// valid/ready output port. An I-format bundle whose immediate does not fit
// in a signed 16-bit field is dropped and flagged with a one-cycle range_err
// pulse.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_imm_sel,
  input  logic [2:0]  in_alu_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        range_err,
  output logic [2:0]  fifo_level,
  output logic [15:0] issued_count
);

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  level;
  logic [31:0] encoded;
  logic        imm_legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Build the instruction word from the incoming fields
  always_comb begin
    encoded = {2'b00, in_imm_sel, in_alu_op, in_rd, in_rs1, 16'h0000};
    if (in_imm_sel) begin
      encoded[15:0] = in_imm[15:0];
    end else begin
      encoded[15:0] = {in_rs2, 11'h000};
    end
  end

  // The immediate must sign-extend cleanly from bit 15
  assign imm_legal = (in_imm[31:15] == '0) || (in_imm[31:15] == '1);

  // in_ready depends only on the registered level, so a full FIFO refuses
  // input even in a cycle where the head is being popped
  assign in_ready   = (level != 3'd4);
  assign accept     = in_valid && in_ready;
  assign push       = accept && (!in_imm_sel || imm_legal);
  assign out_valid  = (level != 3'd0);
  assign pop        = out_valid && out_ready;
  assign fifo_level = level;
  assign out_instr  = out_valid ? mem[rd_ptr] : 32'h0000_0000;

  // FIFO storage: write the encoded word at the tail on a push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (push) begin
      mem[wr_ptr] <= encoded;
    end
  end

  // Pointer, occupancy and issue-counter bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      level        <= 3'd0;
      issued_count <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 2'd1;
        issued_count <= issued_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  // One-cycle error pulse for an accepted I-format bundle with a bad immediate
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err <= 1'b0;
    end else begin
      range_err <= accept && in_imm_sel && !imm_legal;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a table of single-bundle encode vectors,
// followed by hand-written sequences for FIFO fill/drain, simultaneous
// push/pop and mid-stream reset.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_imm_sel;
  logic [2:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        range_err;
  logic [2:0]  fifo_level;
  logic [15:0] issued_count;

  int checks;
  int errors;
  int exp_issued;

  typedef struct {
    logic        imm_sel;
    logic [2:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  instr_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_imm_sel   (in_imm_sel),
    .in_alu_op    (in_alu_op),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .range_err    (range_err),
    .fifo_level   (fifo_level),
    .issued_count (issued_count)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic set_bundle(input logic imm_sel, input logic [2:0] alu_op,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    in_imm_sel = imm_sel;
    in_alu_op  = alu_op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
  endtask

  task automatic apply_stimulus(input vec_t v);
    set_bundle(v.imm_sel, v.alu_op, v.rd, v.rs1, v.rs2, v.imm);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_issued = 0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_issued = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    set_bundle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0);

    vecs[0] = '{1'b0, 3'd2, 5'd1,  5'd2,  5'd3,  32'hDEADBEEF, 32'h08221800, 1'b0};
    vecs[1] = '{1'b1, 3'd1, 5'd5,  5'd6,  5'd31, 32'hFFFFFFFC, 32'h24A6FFFC, 1'b0};
    vecs[2] = '{1'b1, 3'd1, 5'd5,  5'd6,  5'd0,  32'h00008000, 32'h00000000, 1'b1};
    vecs[3] = '{1'b1, 3'd7, 5'd31, 5'd31, 5'd0,  32'h00007FFF, 32'h3FFF7FFF, 1'b0};
    vecs[4] = '{1'b1, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF8000, 32'h20008000, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 5'd4,  5'd4,  5'd0,  32'hFFFF7FFF, 32'h00000000, 1'b1};
    vecs[6] = '{1'b1, 3'd3, 5'd4,  5'd4,  5'd0,  32'h00010000, 32'h00000000, 1'b1};
    vecs[7] = '{1'b0, 3'd7, 5'd31, 5'd31, 5'd31, 32'h00000000, 32'h1FFFF800, 1'b0};
    vecs[8] = '{1'b0, 3'd5, 5'd10, 5'd21, 5'd17, 32'hFFFFFFFF, 32'h15558800, 1'b0};

    step();
    step();
    rst = 1'b0;

    // Reset state
    check_output("rst_level", 32'(fifo_level), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_instr", out_instr, 32'h0);
    check_output("rst_range_err", 32'(range_err), 32'd0);
    check_output("rst_issued", 32'(issued_count), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-bundle encode vectors, each drained on the following edge
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      if (vecs[i].exp_err) begin
        check_output($sformatf("v%0d_range_err", i), 32'(range_err), 32'd1);
        check_output($sformatf("v%0d_level", i), 32'(fifo_level), 32'd0);
        check_output($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd0);
      end else begin
        check_output($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
        check_output($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
        check_output($sformatf("v%0d_range_err", i), 32'(range_err), 32'd0);
        exp_issued++;
      end
      step();
      check_output($sformatf("v%0d_err_cleared", i), 32'(range_err), 32'd0);
      check_output($sformatf("v%0d_drained", i), 32'(fifo_level), 32'd0);
      check_output($sformatf("v%0d_issued", i), 32'(issued_count), 32'(exp_issued));
    end

    // Fill to full with output stalled; fifth bundle must be refused
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      set_bundle(1'b0, 3'd0, 5'(k), 5'd0, 5'd0, 32'h0);
      in_valid = 1'b1;
      step();
      check_output($sformatf("fill%0d_level", k), 32'(fifo_level),
                   (k < 4) ? 32'(k) : 32'd4);
      check_output($sformatf("fill%0d_head_stable", k), out_instr, 32'h00200000);
    end
    check_output("full_in_ready", 32'(in_ready), 32'd0);

    // Full with pop and push offered together: only the pop happens
    set_bundle(1'b0, 3'd0, 5'd6, 5'd0, 5'd0, 32'h0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_output("full_pop_level", 32'(fifo_level), 32'd3);
    check_output("full_pop_head", out_instr, 32'h00400000);
    step();
    check_output("drain_w3", out_instr, 32'h00600000);
    step();
    check_output("drain_w4", out_instr, 32'h00800000);
    step();
    check_output("drain_empty_valid", 32'(out_valid), 32'd0);
    check_output("drain_empty_instr", out_instr, 32'h0);
    check_output("drain_issued", 32'(issued_count), 32'd4);

    // Simultaneous push and pop at level 2
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      set_bundle(1'b0, 3'd0, 5'(k), 5'd0, 5'd0, 32'h0);
      in_valid = 1'b1;
      step();
    end
    check_output("pp_level_before", 32'(fifo_level), 32'd2);
    set_bundle(1'b0, 3'd0, 5'd3, 5'd0, 5'd0, 32'h0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_output("pp_level_after", 32'(fifo_level), 32'd2);
    check_output("pp_head", out_instr, 32'h00400000);
    step();
    check_output("pp_next", out_instr, 32'h00600000);
    step();
    check_output("pp_empty", 32'(fifo_level), 32'd0);
    check_output("pp_issued", 32'(issued_count), 32'd3);

    // Mid-stream reset with level 3 and an illegal bundle on the same edge
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_bundle(1'b0, 3'd1, 5'(k), 5'd1, 5'd1, 32'h0);
      in_valid = 1'b1;
      step();
    end
    check_output("mr_level_before", 32'(fifo_level), 32'd3);
    set_bundle(1'b1, 3'd1, 5'd1, 5'd1, 5'd0, 32'h00008000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_output("mr_level", 32'(fifo_level), 32'd0);
    check_output("mr_out_valid", 32'(out_valid), 32'd0);
    check_output("mr_out_instr", out_instr, 32'h0);
    check_output("mr_issued", 32'(issued_count), 32'd0);
    check_output("mr_in_ready", 32'(in_ready), 32'd1);
    check_output("mr_range_err", 32'(range_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
